// File: rtl/histeq_pkg.sv
// rtl/histeq_pkg.sv - shared sizes, scratch-memory bases and FSM encoding for the CDF builder
package histeq_pkg;

    localparam int NUM_BINS      = 256;
    localparam int BINS_PER_WORD = 4;
    localparam int BIN_W         = 32;
    localparam int WORD_W        = BIN_W * BINS_PER_WORD;
    localparam int ADDR_W        = 16;
    localparam int NUM_WORDS     = NUM_BINS / BINS_PER_WORD;
    localparam int CNT_W         = $clog2(NUM_WORDS);

    localparam logic [ADDR_W-1:0] HIST_BASE = 16'd0;
    localparam logic [ADDR_W-1:0] CDF_BASE  = 16'd64;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cdf_prefix4.sv
// rtl/cdf_prefix4.sv - combinational 4-lane prefix adder; CDF_SAT_EN selects saturating adds
module cdf_prefix4
    import histeq_pkg::*;
(
    input  logic [BIN_W-1:0]  i_acc,
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_cdf,
    output logic [BIN_W-1:0]  o_acc
);

    logic [BIN_W-1:0] w_run;
`ifdef CDF_SAT_EN
    logic [BIN_W:0]   w_sum;
`endif

    always_comb begin
        w_run = i_acc;
        o_cdf = '0;
`ifdef CDF_SAT_EN
        w_sum = '0;
`endif
        for (int i = 0; i < BINS_PER_WORD; i++) begin
`ifdef CDF_SAT_EN
            // carry out means the running total no longer fits; pin it at all-ones
            w_sum = {1'b0, w_run} + {1'b0, i_word[i*BIN_W +: BIN_W]};
            w_run = w_sum[BIN_W] ? {BIN_W{1'b1}} : w_sum[BIN_W-1:0];
`else
            w_run = w_run + i_word[i*BIN_W +: BIN_W];
`endif
            o_cdf[i*BIN_W +: BIN_W] = w_run;
        end
        o_acc = w_run;
    end

endmodule

// File: rtl/cdf_builder.sv
// rtl/cdf_builder.sv - streams the histogram from scratch memory, writes back its CDF, reports cdf_min (CDF_SAT_EN: saturating sums)
module cdf_builder
    import histeq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WORD_W-1:0] cdf_sc_mem_rd_data,
    output logic [ADDR_W-1:0] cdf_sc_mem_rd_addr,
    output logic [ADDR_W-1:0] cdf_sc_mem_wt_addr,
    output logic [WORD_W-1:0] cdf_sc_mem_wt_data,
    output logic              cdf_sc_mem_wt_en,
    output logic              cdf_sc_mem_rd_done,
    output logic              cdf_sc_mem_wt_done,
    output logic              cdf_InProgress,
    output logic [BIN_W-1:0]  cdf_min
);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rd_pend;
    logic [CNT_W-1:0]  r_wr_idx;
    logic [BIN_W-1:0]  r_acc;
    logic [BIN_W-1:0]  r_min;
    logic              r_found;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wt_addr;
    logic [WORD_W-1:0] r_wt_data;
    logic              r_wt_en;

    logic [WORD_W-1:0] w_cdf;
    logic [BIN_W-1:0]  w_acc;
    logic              w_any_nz;
    logic [BIN_W-1:0]  w_first;

    cdf_prefix4 u_prefix (
        .i_acc  (r_acc),
        .i_word (cdf_sc_mem_rd_data),
        .o_cdf  (w_cdf),
        .o_acc  (w_acc)
    );

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_RD;
                ST_RD:    if (r_cnt == LAST_WORD) w_next = ST_DRAIN;
                ST_DRAIN: if (r_cnt == CNT_W'(1)) w_next = ST_DONE;
                ST_DONE:  w_next = ST_DONE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == ST_RD || r_state == ST_DRAIN)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // scanning high-to-low leaves the lowest-index nonzero lane in w_first
    always_comb begin
        w_any_nz = 1'b0;
        w_first  = '0;
        for (int i = BINS_PER_WORD - 1; i >= 0; i--) begin
            if (w_cdf[i*BIN_W +: BIN_W] != '0) begin
                w_any_nz = 1'b1;
                w_first  = w_cdf[i*BIN_W +: BIN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_wr_idx  <= '0;
            r_acc     <= '0;
            r_min     <= '0;
            r_found   <= 1'b0;
            r_rd_addr <= '0;
            r_wt_addr <= '0;
            r_wt_data <= '0;
            r_wt_en   <= 1'b0;
        end else if (!enable) begin
            r_rd_pend <= 1'b0;
            r_wr_idx  <= '0;
            r_acc     <= '0;
            r_min     <= '0;
            r_found   <= 1'b0;
            r_wt_en   <= 1'b0;
        end else begin
            // a read issued in RD returns data one cycle later
            r_rd_pend <= (r_state == ST_RD);
            r_wt_en   <= r_rd_pend;
            if (r_state == ST_IDLE) begin
                r_rd_addr <= HIST_BASE;
                r_wr_idx  <= '0;
                r_acc     <= '0;
                r_min     <= '0;
                r_found   <= 1'b0;
            end else if (r_state == ST_RD && r_cnt != LAST_WORD) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
            if (r_rd_pend) begin
                r_wt_data <= w_cdf;
                r_wt_addr <= CDF_BASE + ADDR_W'(r_wr_idx);
                r_wr_idx  <= r_wr_idx + 1'b1;
                r_acc     <= w_acc;
                if (!r_found && w_any_nz) begin
                    r_min   <= w_first;
                    r_found <= 1'b1;
                end
            end
        end
    end

    assign cdf_sc_mem_rd_addr = r_rd_addr;
    assign cdf_sc_mem_wt_addr = r_wt_addr;
    assign cdf_sc_mem_wt_data = r_wt_data;
    assign cdf_sc_mem_wt_en   = r_wt_en;
    assign cdf_sc_mem_rd_done = (r_state == ST_DRAIN) || (r_state == ST_DONE);
    assign cdf_sc_mem_wt_done = (r_state == ST_DONE);
    assign cdf_InProgress     = (r_state == ST_RD) || (r_state == ST_DRAIN);
    assign cdf_min            = r_min;

endmodule

// File: tb/tb_cdf_builder.sv
// tb/tb_cdf_builder.sv - table-driven bench for cdf_builder with a scratch-memory model
module tb_cdf_builder;
    import histeq_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [127:0] rd_data;
    logic [15:0]  rd_addr;
    logic [15:0]  wt_addr;
    logic [127:0] wt_data;
    logic         wt_en;
    logic         rd_done;
    logic         wt_done;
    logic         in_prog;
    logic [31:0]  cmin;

    always #5 clk = ~clk;

    cdf_builder dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .cdf_sc_mem_rd_data (rd_data),
        .cdf_sc_mem_rd_addr (rd_addr),
        .cdf_sc_mem_wt_addr (wt_addr),
        .cdf_sc_mem_wt_data (wt_data),
        .cdf_sc_mem_wt_en   (wt_en),
        .cdf_sc_mem_rd_done (rd_done),
        .cdf_sc_mem_wt_done (wt_done),
        .cdf_InProgress     (in_prog),
        .cdf_min            (cmin)
    );

    logic [127:0] hist_mem [0:63];
    logic [127:0] exp_cdf  [0:63];
    logic [15:0]  rd_idx;

    assign rd_idx = rd_addr - HIST_BASE;
    always @(posedge clk) rd_data <= hist_mem[rd_idx[5:0]];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_bin(input int b, input logic [31:0] v);
        hist_mem[b / 4][(b % 4) * 32 +: 32] = v;
    endtask

    task automatic fill_pattern(input int p);
        for (int w = 0; w < 64; w++) hist_mem[w] = '0;
        case (p)
            0: for (int b = 0; b < 256; b++) set_bin(b, 32'd1);
            1: begin set_bin(10, 32'd5); set_bin(255, 32'd7); end
            3: begin set_bin(0, 32'hFFFF_FFF0); set_bin(1, 32'h20); end
            default: ;
        endcase
    endtask

    task automatic build_model();
        longint unsigned acc;
        logic [31:0] b;
        acc = 0;
        for (int w = 0; w < 64; w++) begin
            for (int l = 0; l < 4; l++) begin
                b = hist_mem[w][l*32 +: 32];
                acc = acc + longint'(b);
`ifdef CDF_SAT_EN
                if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
`else
                acc = acc & 64'hFFFF_FFFF;
`endif
                exp_cdf[w][l*32 +: 32] = acc[31:0];
            end
        end
    endtask

    // cycle n is the cycle after the n-th rising edge following the enable rise
    task automatic run_full(input string tag, input logic [31:0] e_min,
                            input logic [31:0] e_top, input logic [127:0] e_w0);
        int idx;
        @(negedge clk);
        enable = 1'b1;
        for (int n = 1; n <= 72; n++) begin
            @(posedge clk);
            #1;
            chk({tag, " wt_en"},   wt_en,   (n >= 3 && n <= 66));
            chk({tag, " in_prog"}, in_prog, (n >= 1 && n <= 66));
            chk({tag, " rd_done"}, rd_done, (n >= 65));
            chk({tag, " wt_done"}, wt_done, (n >= 67));
            if (n <= 64) chk({tag, " rd_addr"}, rd_addr, HIST_BASE + 16'(n - 1));
            else         chk({tag, " rd_addr_hold"}, rd_addr, HIST_BASE + 16'd63);
            idx = n - 3;
            if (wt_en && idx >= 0 && idx < 64) begin
                chk({tag, " wt_addr"}, wt_addr, CDF_BASE + 16'(idx));
                chk({tag, " wt_data"}, wt_data, exp_cdf[idx]);
                if (idx == 0)  chk({tag, " word0"}, wt_data, e_w0);
                if (idx == 63) chk({tag, " top_lane"}, wt_data[127:96], e_top);
            end
            if (n >= 67) chk({tag, " cdf_min"}, cmin, e_min);
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " idle_wt_done"}, wt_done, 1'b0);
        chk({tag, " idle_rd_done"}, rd_done, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_addr"}, rd_addr, 16'd0);
        chk({tag, " wt_addr"}, wt_addr, 16'd0);
        chk({tag, " wt_data"}, wt_data, 128'd0);
        chk({tag, " wt_en"},   wt_en,   1'b0);
        chk({tag, " rd_done"}, rd_done, 1'b0);
        chk({tag, " wt_done"}, wt_done, 1'b0);
        chk({tag, " in_prog"}, in_prog, 1'b0);
        chk({tag, " cdf_min"}, cmin,    32'd0);
    endtask

    typedef struct {
        string        name;
        int           pat;
        logic [31:0]  e_min;
        logic [31:0]  e_top;
        logic [127:0] e_w0;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{"ones",   0, 32'd1, 32'd256, {32'd4, 32'd3, 32'd2, 32'd1}};
        vecs[1] = '{"sparse", 1, 32'd5, 32'd12,  128'd0};
        vecs[2] = '{"zeros",  2, 32'd0, 32'd0,   128'd0};
`ifdef CDF_SAT_EN
        vecs[3] = '{"ovf",    3, 32'hFFFF_FFF0, 32'hFFFF_FFFF,
                    {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0}};
`else
        vecs[3] = '{"ovf",    3, 32'hFFFF_FFF0, 32'h10,
                    {32'h10, 32'h10, 32'h10, 32'hFFFF_FFF0}};
`endif

        reset  = 1'b1;
        enable = 1'b0;
        fill_pattern(2);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            fill_pattern(vecs[v].pat);
            build_model();
            run_full(vecs[v].name, vecs[v].e_min, vecs[v].e_top, vecs[v].e_w0);
        end

        // sparse run: lanes before bin 10 stay zero
        fill_pattern(1);
        build_model();
        chk("sparse word2", exp_cdf[2], {32'd5, 32'd5, 32'd0, 32'd0});

        // reset during cycle 30 of a run
        fill_pattern(0);
        build_model();
        @(negedge clk);
        enable = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midrun wt_en", wt_en, 1'b1);
        chk("midrun cdf_min", cmin, 32'd1);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        run_full("after_reset", 32'd1, 32'd256, {32'd4, 32'd3, 32'd2, 32'd1});

        // abort by dropping enable during cycle 20
        @(negedge clk);
        enable = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            chk("abort wt_en",   wt_en,   1'b0);
            chk("abort rd_done", rd_done, 1'b0);
            chk("abort wt_done", wt_done, 1'b0);
            chk("abort in_prog", in_prog, 1'b0);
            chk("abort cdf_min", cmin,    32'd0);
        end
        run_full("after_abort", 32'd1, 32'd256, {32'd4, 32'd3, 32'd2, 32'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
